// File: rtl/ray_pkg.sv
// Shared types for the voxel DDA stepper: axis and FSM encodings, job and result records.
// Struct field widths follow the default grid geometry; the top rejects mismatched overrides.
package ray_pkg;

    localparam int RAY_X_BITS     = 5;
    localparam int RAY_Y_BITS     = 5;
    localparam int RAY_Z_BITS     = 5;
    localparam int RAY_W          = 24;
    localparam int RAY_STEPS_BITS = 10;

    typedef enum logic [1:0] {
        AX_X    = 2'd0,
        AX_Y    = 2'd1,
        AX_Z    = 2'd2,
        AX_NONE = 2'd3
    } axis_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CHECK = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [RAY_X_BITS-1:0]     ix;
        logic [RAY_Y_BITS-1:0]     iy;
        logic [RAY_Z_BITS-1:0]     iz;
        logic                      sx;
        logic                      sy;
        logic                      sz;
        logic [RAY_W-1:0]          next_x;
        logic [RAY_W-1:0]          next_y;
        logic [RAY_W-1:0]          next_z;
        logic [RAY_W-1:0]          inc_x;
        logic [RAY_W-1:0]          inc_y;
        logic [RAY_W-1:0]          inc_z;
        logic [RAY_STEPS_BITS-1:0] max_steps;
        logic [15:0]               px;
        logic [15:0]               py;
    } ray_job_t;

    typedef struct packed {
        logic                      hit;
        logic [RAY_X_BITS-1:0]     x;
        logic [RAY_Y_BITS-1:0]     y;
        logic [RAY_Z_BITS-1:0]     z;
        logic [RAY_STEPS_BITS-1:0] steps;
        axis_t                     face;
        logic [15:0]               px;
        logic [15:0]               py;
    } ray_result_t;

    // True when one more step in direction s would leave a grid of 2^bits cells.
    function automatic logic at_bound(input logic [31:0] idx, input int unsigned bits,
                                      input logic s);
        logic [31:0] top;
        top = (32'd1 << bits) - 32'd1;
        return s ? (idx == top) : (idx == 32'd0);
    endfunction

endpackage

// File: rtl/ray_axis_select.sv
// Picks the axis with the smallest next-boundary distance; ties favour x, then y, then z.
module ray_axis_select
    import ray_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] nx_i,
    input  logic [W-1:0] ny_i,
    input  logic [W-1:0] nz_i,
    output axis_t        axis_o
);

    always_comb begin
        axis_o = AX_Z;
        if (nx_i <= ny_i && nx_i <= nz_i) begin
            axis_o = AX_X;
        end else if (ny_i <= nz_i) begin
            axis_o = AX_Y;
        end
    end

endmodule

// File: rtl/ray_dda_stepper.sv
// 3D-DDA voxel walker: takes one ray job, probes occupancy per cell (2 cycles/voxel),
// and reports hit/miss with the final voxel, advance count and last-step axis.
module ray_dda_stepper
    import ray_pkg::*;
#(
    parameter int X_BITS         = 5,
    parameter int Y_BITS         = 5,
    parameter int Z_BITS         = 5,
    parameter int W              = 24,
    parameter int MAX_STEPS_BITS = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_mode,
    input  logic                             job_valid,
    output logic                             job_ready,
    input  logic [X_BITS-1:0]                ix0,
    input  logic [Y_BITS-1:0]                iy0,
    input  logic [Z_BITS-1:0]                iz0,
    input  logic                             sx,
    input  logic                             sy,
    input  logic                             sz,
    input  logic [W-1:0]                     next_x,
    input  logic [W-1:0]                     next_y,
    input  logic [W-1:0]                     next_z,
    input  logic [W-1:0]                     inc_x,
    input  logic [W-1:0]                     inc_y,
    input  logic [W-1:0]                     inc_z,
    input  logic [MAX_STEPS_BITS-1:0]        max_steps,
    input  logic [15:0]                      px_in,
    input  logic [15:0]                      py_in,
    output logic                             occ_rd_en,
    output logic [X_BITS+Y_BITS+Z_BITS-1:0]  occ_addr,
    input  logic                             occ_rd_data,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic                             res_hit,
    output logic [X_BITS-1:0]                res_x,
    output logic [Y_BITS-1:0]                res_y,
    output logic [Z_BITS-1:0]                res_z,
    output logic [MAX_STEPS_BITS-1:0]        res_steps,
    output logic [1:0]                       res_face,
    output logic [15:0]                      res_px,
    output logic [15:0]                      res_py,
    output logic                             busy
);

    // The job/result records are laid out with the package geometry.
    if (X_BITS != RAY_X_BITS || Y_BITS != RAY_Y_BITS || Z_BITS != RAY_Z_BITS ||
        W != RAY_W || MAX_STEPS_BITS != RAY_STEPS_BITS) begin : g_width_check
        $error("ray_dda_stepper parameters must match ray_pkg geometry");
    end

    state_t                    state_q, state_d;
    ray_job_t                  job_q, job_d;
    ray_job_t                  job_in;
    logic [MAX_STEPS_BITS-1:0] steps_q, steps_d;
    axis_t                     face_q, face_d;
    logic                      hit_q, hit_d;
    axis_t                     sel;
    ray_result_t               res;

    assign job_in = '{ix: ix0, iy: iy0, iz: iz0, sx: sx, sy: sy, sz: sz,
                      next_x: next_x, next_y: next_y, next_z: next_z,
                      inc_x: inc_x, inc_y: inc_y, inc_z: inc_z,
                      max_steps: max_steps, px: px_in, py: py_in};

    ray_axis_select #(.W(W)) u_axis_select (
        .nx_i   (job_q.next_x),
        .ny_i   (job_q.next_y),
        .nz_i   (job_q.next_z),
        .axis_o (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            job_q   <= '0;
            steps_q <= '0;
            face_q  <= AX_NONE;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            steps_q <= steps_d;
            face_q  <= face_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        job_d     = job_q;
        steps_d   = steps_q;
        face_d    = face_q;
        hit_d     = hit_q;
        job_ready = 1'b0;
        occ_rd_en = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                job_ready = !load_mode;
                if (job_valid && !load_mode) begin
                    job_d   = job_in;
                    steps_d = '0;
                    face_d  = AX_NONE;
                    hit_d   = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                occ_rd_en = 1'b1;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (occ_rd_data) begin
                    hit_d   = 1'b1;
                    state_d = S_OUT;
                end else if (steps_q == job_q.max_steps) begin
                    state_d = S_OUT;
                end else begin
                    // Leaving the grid ends the walk as a miss with the voxel unchanged.
                    state_d = S_READ;
                    case (sel)
                        AX_X: begin
                            if (at_bound(32'(job_q.ix), X_BITS, job_q.sx)) begin
                                state_d = S_OUT;
                            end else begin
                                job_d.ix     = job_q.sx ? job_q.ix + 1'b1 : job_q.ix - 1'b1;
                                job_d.next_x = job_q.next_x + job_q.inc_x;
                                steps_d      = steps_q + 1'b1;
                                face_d       = AX_X;
                            end
                        end
                        AX_Y: begin
                            if (at_bound(32'(job_q.iy), Y_BITS, job_q.sy)) begin
                                state_d = S_OUT;
                            end else begin
                                job_d.iy     = job_q.sy ? job_q.iy + 1'b1 : job_q.iy - 1'b1;
                                job_d.next_y = job_q.next_y + job_q.inc_y;
                                steps_d      = steps_q + 1'b1;
                                face_d       = AX_Y;
                            end
                        end
                        AX_Z: begin
                            if (at_bound(32'(job_q.iz), Z_BITS, job_q.sz)) begin
                                state_d = S_OUT;
                            end else begin
                                job_d.iz     = job_q.sz ? job_q.iz + 1'b1 : job_q.iz - 1'b1;
                                job_d.next_z = job_q.next_z + job_q.inc_z;
                                steps_d      = steps_q + 1'b1;
                                face_d       = AX_Z;
                            end
                        end
                        default: state_d = S_OUT;
                    endcase
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result fields are the live walker registers; they freeze once in S_OUT.
    assign res = '{hit: hit_q, x: job_q.ix, y: job_q.iy, z: job_q.iz, steps: steps_q,
                   face: face_q, px: job_q.px, py: job_q.py};

    assign occ_addr  = {job_q.iz, job_q.iy, job_q.ix};
    assign res_hit   = res.hit;
    assign res_x     = res.x;
    assign res_y     = res.y;
    assign res_z     = res.z;
    assign res_steps = res.steps;
    assign res_face  = res.face;
    assign res_px    = res.px;
    assign res_py    = res.py;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ray_dda_stepper.sv
// Directed bench for ray_dda_stepper with a synchronous 1-bit occupancy memory model.
module tb_ray_dda_stepper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_mode, job_valid, job_ready;
    logic [4:0]  ix0, iy0, iz0;
    logic        sx, sy, sz;
    logic [23:0] next_x, next_y, next_z, inc_x, inc_y, inc_z;
    logic [9:0]  max_steps;
    logic [15:0] px_in, py_in;
    logic        occ_rd_en;
    logic [14:0] occ_addr;
    logic        occ_rd_data;
    logic        res_valid, res_ready, res_hit;
    logic [4:0]  res_x, res_y, res_z;
    logic [9:0]  res_steps;
    logic [1:0]  res_face;
    logic [15:0] res_px, res_py;
    logic        busy;

    bit occ_mem [0:32767];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (occ_rd_en) occ_rd_data <= occ_mem[occ_addr];
    end

    ray_dda_stepper dut (
        .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .job_valid(job_valid),
        .job_ready(job_ready), .ix0(ix0), .iy0(iy0), .iz0(iz0), .sx(sx), .sy(sy), .sz(sz),
        .next_x(next_x), .next_y(next_y), .next_z(next_z),
        .inc_x(inc_x), .inc_y(inc_y), .inc_z(inc_z), .max_steps(max_steps),
        .px_in(px_in), .py_in(py_in), .occ_rd_en(occ_rd_en), .occ_addr(occ_addr),
        .occ_rd_data(occ_rd_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_hit(res_hit), .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .res_steps(res_steps), .res_face(res_face), .res_px(res_px), .res_py(res_py),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) occ_mem[i] = 1'b0;
    endtask

    task automatic set_occ(input int x, input int y, input int z);
        occ_mem[z*1024 + y*32 + x] = 1'b1;
    endtask

    // Presents a job for one edge; on return the bench is in cycle N+1.
    task automatic send_job(input int x, input int y, input int z,
                            input logic dx, input logic dy, input logic dz,
                            input int nx, input int ny, input int nz,
                            input int ax, input int ay, input int az,
                            input int ms, input int tx, input int ty);
        ix0 = 5'(x); iy0 = 5'(y); iz0 = 5'(z);
        sx = dx; sy = dy; sz = dz;
        next_x = 24'(nx); next_y = 24'(ny); next_z = 24'(nz);
        inc_x = 24'(ax); inc_y = 24'(ay); inc_z = 24'(az);
        max_steps = 10'(ms); px_in = 16'(tx); py_in = 16'(ty);
        job_valid = 1'b1;
        cyc();
        job_valid = 1'b0;
    endtask

    // Waits for the result, checks it and the N+3+2k latency, then retires it.
    task automatic expect_res(input string tag, input int hit, input int x, input int y,
                              input int z, input int steps, input int face,
                              input int tx, input int ty);
        int lat;
        lat = 0;
        chk({tag, ".rd_en"}, 32'(occ_rd_en), 32'd1);
        while (!res_valid && lat < 300) begin
            cyc();
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(2 + 2*steps));
        chk({tag, ".hit"}, 32'(res_hit), 32'(hit));
        chk({tag, ".xyz"}, {17'd0, res_z, res_y, res_x}, 32'(z*1024 + y*32 + x));
        chk({tag, ".steps"}, 32'(res_steps), 32'(steps));
        chk({tag, ".face"}, 32'(res_face), 32'(face));
        chk({tag, ".tag"}, {res_px, res_py}, {16'(tx), 16'(ty)});
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        chk({tag, ".idle"}, {30'd0, res_valid, job_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; load_mode = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
        occ_rd_data = 1'b0;
        ix0 = '0; iy0 = '0; iz0 = '0; sx = 1'b0; sy = 1'b0; sz = 1'b0;
        next_x = '0; next_y = '0; next_z = '0; inc_x = '0; inc_y = '0; inc_z = '0;
        max_steps = '0; px_in = '0; py_in = '0;
        clear_mem();
        cyc(); cyc();

        chk("rst.ctl", {28'd0, job_ready, res_valid, occ_rd_en, busy}, 32'b1000);
        chk("rst.res", {7'd0, res_hit, res_x, res_y, res_z, res_steps}, 32'd0);
        chk("rst.face", 32'(res_face), 32'd3);
        chk("rst.addr", 32'(occ_addr), 32'd0);
        chk("rst.tag", {res_px, res_py}, 32'd0);
        #2 rst_n = 1'b1;
        cyc();

        // Start voxel occupied: immediate hit.
        set_occ(3, 3, 3);
        send_job(3, 3, 3, 1, 1, 1, 5, 6, 7, 1, 1, 1, 10, 16'h1234, 16'h5678);
        chk("t1.busy", {30'd0, busy, job_ready}, 32'b10);
        expect_res("t1", 1, 3, 3, 3, 0, 3, 16'h1234, 16'h5678);

        // Two x advances to (2,0,0).
        clear_mem(); set_occ(2, 0, 0);
        send_job(0, 0, 0, 1, 1, 1, 1, 5, 5, 2, 10, 10, 20, 16'h0002, 16'h0003);
        expect_res("t2", 1, 2, 0, 0, 2, 0, 16'h0002, 16'h0003);

        // x at the top bound stepping +1: bound exit.
        clear_mem();
        send_job(31, 0, 0, 1, 1, 1, 1, 5, 5, 2, 10, 10, 20, 16'h0031, 16'h0000);
        expect_res("t3", 0, 31, 0, 0, 0, 3, 16'h0031, 16'h0000);

        // z at 0 stepping -1: bound exit.
        send_job(0, 0, 0, 1, 1, 0, 9, 9, 1, 1, 1, 1, 20, 16'h0004, 16'h0004);
        expect_res("t3z", 0, 0, 0, 0, 0, 3, 16'h0004, 16'h0004);

        // Step limit: x(3), y(4), z(5), x(9) then stop at 4 advances.
        send_job(10, 10, 10, 1, 0, 1, 3, 4, 5, 6, 6, 6, 4, 16'h0aaa, 16'h0bbb);
        expect_res("t4", 0, 12, 9, 11, 4, 0, 16'h0aaa, 16'h0bbb);

        // max_steps = 0 tests only the start voxel.
        send_job(7, 7, 7, 1, 1, 1, 1, 2, 3, 1, 1, 1, 0, 16'h0007, 16'h0000);
        expect_res("t0", 0, 7, 7, 7, 0, 3, 16'h0007, 16'h0000);

        // Three-way tie advances x first.
        set_occ(6, 5, 5);
        send_job(5, 5, 5, 1, 1, 1, 8, 8, 8, 1, 1, 1, 10, 16'h0008, 16'h0008);
        expect_res("tie", 1, 6, 5, 5, 1, 0, 16'h0008, 16'h0008);

        // Backpressure: result held, stray job_valid ignored.
        clear_mem(); set_occ(3, 3, 3);
        send_job(3, 3, 3, 1, 1, 1, 5, 6, 7, 1, 1, 1, 10, 16'h00bb, 16'h00cc);
        cyc(); cyc();
        chk("bp.valid0", 32'(res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            job_valid = (i == 2);
            cyc();
            chk("bp.hold", {13'd0, res_valid, job_ready, res_hit, res_x, res_y, res_z, res_face},
                {13'd0, 1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 2'd3});
        end
        job_valid = 1'b0;
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        cyc();
        chk("bp.noacc", {30'd0, busy, job_ready}, 32'b01);

        // load_mode blocks acceptance.
        load_mode = 1'b1;
        #1 chk("lm.ready", 32'(job_ready), 32'd0);
        job_valid = 1'b1;
        cyc();
        job_valid = 1'b0;
        chk("lm.busy", 32'(busy), 32'd0);
        load_mode = 1'b0;
        cyc();
        chk("lm.after", {30'd0, busy, job_ready}, 32'b01);

        // Reset mid-walk discards the job.
        clear_mem();
        send_job(10, 10, 10, 1, 0, 1, 3, 4, 5, 6, 6, 6, 4, 16'h0eee, 16'h0fff);
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        #1;
        chk("mr.ctl", {28'd0, job_ready, res_valid, occ_rd_en, busy}, 32'b1000);
        chk("mr.res", {res_x, res_y, res_z, res_steps, 2'd0}, 32'd0);
        chk("mr.face", 32'(res_face), 32'd3);
        cyc();
        rst_n = 1'b1;
        cyc();
        set_occ(3, 3, 3);
        send_job(3, 3, 3, 1, 1, 1, 5, 6, 7, 1, 1, 1, 10, 16'h0111, 16'h0222);
        expect_res("mr.job", 1, 3, 3, 3, 0, 3, 16'h0111, 16'h0222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ray_dda_stepper.md
# ray_dda_stepper

Voxel-traversal core directly downstream of the ray job source. It accepts one precomputed 3D-DDA ray job at a time over a valid/ready handshake and walks the voxel grid one cell per iteration, reading a 1-bit occupancy memory for each cell. It reports hit or miss, the final voxel, the step count and the entry face, then returns to idle for the next job.

## Interface
Parameters:
- X_BITS, 5, voxel x index width
- Y_BITS, 5, voxel y index width
- Z_BITS, 5, voxel z index width
- W, 24, width of next_*/inc_* fixed-point distances (unsigned)
- MAX_STEPS_BITS, 10, step counter / limit width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- load_mode  in  1  scene load in progress; blocks job acceptance
- job_valid  in  1  job present (may be a single-cycle pulse)
- job_ready  out  1  stepper can accept a job this cycle
- ix0/iy0/iz0  in  X_BITS/Y_BITS/Z_BITS  start voxel
- sx/sy/sz  in  1 each  step direction per axis (1 = +1, 0 = −1)
- next_x/next_y/next_z  in  W each  distance to the next boundary per axis
- inc_x/inc_y/inc_z  in  W each  per-axis boundary spacing
- max_steps  in  MAX_STEPS_BITS  maximum voxel advances
- px_in/py_in  in  16 each  pixel tag, passed through
- occ_rd_en  out  1  occupancy read strobe
- occ_addr  out  X_BITS+Y_BITS+Z_BITS  {iz,iy,ix}
- occ_rd_data  in  1  occupancy, valid 1 cycle after occ_rd_en
- res_valid  out  1  result valid, held until res_ready
- res_ready  in  1  consumer accepts result
- res_hit  out  1  1 = occupied voxel found
- res_x/res_y/res_z  out  X_BITS/Y_BITS/Z_BITS  final voxel
- res_steps  out  MAX_STEPS_BITS  voxel advances performed
- res_face  out  2  axis of the last step (0 = x, 1 = y, 2 = z, 3 = none, start voxel)
- res_px/res_py  out  16 each  tag of the job
- busy  out  1  state != S_IDLE

## Operation
- States: S_IDLE, S_READ, S_CHECK, S_OUT.
- S_IDLE:
  - job_ready = !load_mode.
  - When job_valid && job_ready: latch all job fields and tags, clear steps to 0, set face = 3, go to S_READ.
- S_READ: drive occ_rd_en = 1 with occ_addr = current voxel, then go to S_CHECK.
- S_CHECK:
  - If occ_rd_data = 1: hit, go to S_OUT.
  - Else if steps == max_steps: miss, go to S_OUT.
  - Otherwise select the axis with the minimum next_* value (ties resolve x > y > z).
  - If the selected index is at its bound (all ones with s = 1, or 0 with s = 0): miss, go to S_OUT, voxel unchanged.
  - Otherwise update the selected axis:
    - index ±1
    - next_a ← next_a + inc_a, modulo 2^W, no saturation
    - steps + 1
    - face = axis
  - Then go to S_READ.
- S_OUT: res_valid = 1 with all res_* stable. When res_ready is high, go to S_IDLE.
- job_valid outside S_IDLE, or while load_mode = 1, is ignored and no job is captured.
- max_steps = 0: only the start voxel is tested.
- res_steps never exceeds max_steps.

## Timing
- Reset values:
  - state S_IDLE
  - job_ready = 1 (gated by load_mode)
  - res_valid, occ_rd_en, busy = 0
  - res_hit, res_x/y/z, res_steps, res_px/py, occ_addr = 0
  - res_face = 3
- Acceptance edge at cycle N:
  - occ_rd_en in cycle N+1
  - decision in cycle N+2
  - res_valid earliest in cycle N+3
- Each voxel costs 2 cycles, so a result after k advances appears in cycle N+3+2k.
- job_ready is registered from state and deasserts the cycle after acceptance.
- A job pulse that arrives one cycle after ready was sampled high is still accepted, because ready remains high throughout S_IDLE.
- Backpressure: res_valid stays asserted and the outputs hold while res_ready = 0.
- res_ready high in the first S_OUT cycle gives S_IDLE on the next cycle.
- rst_n asserted mid-traversal: outputs immediately take their reset values and the in-flight job is discarded.

## Structure
- Package ray_pkg holds:
  - axis_t enum (AX_X = 0, AX_Y = 1, AX_Z = 2, AX_NONE = 3)
  - ray_job_t packed struct of the job fields
  - ray_result_t packed struct of the result fields
- Sub-module ray_axis_select: combinational minimum of three W-bit values with x > y > z tie-break, output axis_t.

## Test plan
- Start (3,3,3), only voxel (3,3,3) occupied, max_steps = 10 → hit, res=(3,3,3), steps 0, face 3, res_valid 3 cycles after acceptance.
- Start (0,0,0), sx = 1, next=(1,5,5), inc=(2,10,10), occupied (2,0,0) → hit at (2,0,0), steps 2, face 0, result in cycle N+7.
- Start (31,0,0), sx = 1, next_x minimum, empty grid → miss, res=(31,0,0), steps 0 (bound exit).
- Empty grid, max_steps = 4, interior start → miss, steps 4.
- Tie next=(8,8,8) → x chosen first.
- res_ready held low 5 cycles → outputs stable and job_ready low. load_mode = 1 with a job_valid pulse → not accepted.
- rst_n pulsed mid-walk → res_valid = 0, state S_IDLE, next job processes normally.
